mc_control_unit: RTL and testbench

- Moore-style multicycle controller that sequences the MIPS datapath: PC, instruction/data memory, IR, MDR, register file, ULA and its operand muxes.
- Drives every select and write-enable, including the 2-bit ULA operand-A select (00 = PC, 01 = MDR, 10 = A).
- Sits beside the datapath top and takes only the IR opcode/funct fields.
- Implements a configurable memory wait so slow memories can be used without datapath changes.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/mc_wait_counter.sv | 27 ++
 rtl/mc_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath:
// state enum, opcode/funct constants and mux/ULA select codes.
package mc_ctrl_pkg;

   typedef enum logic [4:0] {
      ST_RESET      = 5'd0,
      ST_FETCH      = 5'd1,
      ST_FETCH_WAIT = 5'd2,
      ST_FETCH_END  = 5'd3,
      ST_DECODE     = 5'd4,
      ST_R_EXEC     = 5'd5,
      ST_R_WB       = 5'd6,
      ST_ADDI_EXEC  = 5'd7,
      ST_ADDI_WB    = 5'd8,
      ST_MEM_ADDR   = 5'd9,
      ST_LW_READ    = 5'd10,
      ST_LW_WAIT    = 5'd11,
      ST_LW_MDR     = 5'd12,
      ST_LW_WB      = 5'd13,
      ST_SW_WRITE   = 5'd14,
      ST_BEQ        = 5'd15,
      ST_JUMP       = 5'd16,
      ST_ILLEGAL    = 5'd17
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [2:0] ULAOP_IDLE = 3'b000;
   localparam logic [2:0] ULAOP_ADD  = 3'b001;
   localparam logic [2:0] ULAOP_SUB  = 3'b010;
   localparam logic [2:0] ULAOP_AND  = 3'b011;

   localparam logic [1:0] ULAA_PC  = 2'b00;
   localparam logic [1:0] ULAA_MDR = 2'b01;
   localparam logic [1:0] ULAA_A   = 2'b10;

   localparam logic [1:0] ULAB_B       = 2'b00;
   localparam logic [1:0] ULAB_FOUR    = 2'b01;
   localparam logic [1:0] ULAB_IMM     = 2'b10;
   localparam logic [1:0] ULAB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ULA    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Unsupported funct codes map to IDLE, which the FSM treats as illegal.
   function automatic logic [2:0] funct_to_ulaop(input logic [5:0] f);
      logic [2:0] op;
      case (f)
         FN_ADD:  op = ULAOP_ADD;
         FN_SUB:  op = ULAOP_SUB;
         FN_AND:  op = ULAOP_AND;
         default: op = ULAOP_IDLE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// 4-bit memory wait counter: load, saturating decrement, done at 1 or below.
module mc_wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       dec,
   input  logic [3:0] load_val,
   output logic       done
);
   logic [3:0] count_r;

   // Counter register; decrement holds at zero so it can never wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 4'd0;
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != 4'd0)) begin
         count_r <= count_r - 4'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r <= 4'd1);

endmodule

// File: rtl/mc_control_unit.sv
// Moore multicycle controller for the MIPS datapath. Outputs decode only from
// registered state, so reset drops every strobe without waiting for a clock.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [1:0] ULAa,
   output logic [1:0] ULAb,
   output logic [2:0] ULAop,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MDRWrite,
   output logic       ALUOutWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic       op_error,
   output logic [4:0] state_dbg
);
   localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);
   localparam logic       HAS_WAIT  = (MEM_WAIT > 0) ? 1'b1 : 1'b0;

   state_t     state_r;
   state_t     state_s;
   logic [2:0] r_ulaop_r;
   logic       r_ok_r;
   logic       is_sw_r;
   logic       cnt_load_s;
   logic       cnt_dec_s;
   logic       cnt_done_s;

   mc_wait_counter u_wait (
      .clk      (clk),
      .rst      (reset),
      .load     (cnt_load_s),
      .dec      (cnt_dec_s),
      .load_val (WAIT_LOAD),
      .done     (cnt_done_s)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_RESET;
      end else begin
         state_r <= state_s;
      end
   end

   // IR fields are captured in DECODE so R_EXEC outputs come from flops, not inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ulaop_r <= ULAOP_IDLE;
         r_ok_r    <= 1'b0;
         is_sw_r   <= 1'b0;
      end else if (state_r == ST_DECODE) begin
         r_ulaop_r <= funct_to_ulaop(funct);
         r_ok_r    <= (funct_to_ulaop(funct) != ULAOP_IDLE);
         is_sw_r   <= (opcode == OP_SW);
      end else begin
         r_ulaop_r <= r_ulaop_r;
         r_ok_r    <= r_ok_r;
         is_sw_r   <= is_sw_r;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_s     = state_r;
      cnt_load_s  = 1'b0;
      cnt_dec_s   = 1'b0;
      ULAa        = ULAA_PC;
      ULAb        = ULAB_B;
      ULAop       = ULAOP_IDLE;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MDRWrite    = 1'b0;
      ALUOutWrite = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = PCSRC_ULA;
      op_error    = 1'b0;
      case (state_r)
         ST_RESET: state_s = ST_FETCH;
         ST_FETCH: begin
            cnt_load_s = 1'b1;
            state_s    = HAS_WAIT ? ST_FETCH_WAIT : ST_FETCH_END;
         end
         ST_FETCH_WAIT: begin
            cnt_dec_s = 1'b1;
            state_s   = cnt_done_s ? ST_FETCH_END : ST_FETCH_WAIT;
         end
         ST_FETCH_END: begin
            IRWrite  = 1'b1;
            ULAb     = ULAB_FOUR;
            ULAop    = ULAOP_ADD;
            PCWrite  = 1'b1;
            state_s  = ST_DECODE;
         end
         ST_DECODE: begin
            ULAb        = ULAB_IMM_SH2;
            ULAop       = ULAOP_ADD;
            ALUOutWrite = 1'b1;
            case (opcode)
               OP_RTYPE:     state_s = ST_R_EXEC;
               OP_ADDI:      state_s = ST_ADDI_EXEC;
               OP_LW, OP_SW: state_s = ST_MEM_ADDR;
               OP_BEQ:       state_s = ST_BEQ;
               OP_J:         state_s = ST_JUMP;
               default:      state_s = ST_ILLEGAL;
            endcase
         end
         ST_R_EXEC: begin
            ULAa = ULAA_A;
            ULAb = ULAB_B;
            if (r_ok_r) begin
               ULAop       = r_ulaop_r;
               ALUOutWrite = 1'b1;
               state_s     = ST_R_WB;
            end else begin
               state_s     = ST_ILLEGAL;
            end
         end
         ST_R_WB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            state_s  = ST_FETCH;
         end
         ST_ADDI_EXEC: begin
            ULAa        = ULAA_A;
            ULAb        = ULAB_IMM;
            ULAop       = ULAOP_ADD;
            ALUOutWrite = 1'b1;
            state_s     = ST_ADDI_WB;
         end
         ST_ADDI_WB: begin
            RegWrite = 1'b1;
            state_s  = ST_FETCH;
         end
         ST_MEM_ADDR: begin
            ULAa        = ULAA_A;
            ULAb        = ULAB_IMM;
            ULAop       = ULAOP_ADD;
            ALUOutWrite = 1'b1;
            state_s     = is_sw_r ? ST_SW_WRITE : ST_LW_READ;
         end
         ST_LW_READ: begin
            IorD       = 1'b1;
            cnt_load_s = 1'b1;
            state_s    = HAS_WAIT ? ST_LW_WAIT : ST_LW_MDR;
         end
         // The data address is held through the wait so a slow memory sees it stable.
         ST_LW_WAIT: begin
            IorD      = 1'b1;
            cnt_dec_s = 1'b1;
            state_s   = cnt_done_s ? ST_LW_MDR : ST_LW_WAIT;
         end
         ST_LW_MDR: begin
            IorD     = 1'b1;
            MDRWrite = 1'b1;
            state_s  = ST_LW_WB;
         end
         ST_LW_WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            state_s  = ST_FETCH;
         end
         ST_SW_WRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            state_s  = ST_FETCH;
         end
         ST_BEQ: begin
            ULAa        = ULAA_A;
            ULAb        = ULAB_B;
            ULAop       = ULAOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            state_s     = ST_FETCH;
         end
         ST_JUMP: begin
            PCSource = PCSRC_JUMP;
            PCWrite  = 1'b1;
            state_s  = ST_FETCH;
         end
         ST_ILLEGAL: begin
            op_error = 1'b1;
            state_s  = ST_FETCH;
         end
         default: state_s = ST_FETCH;
      endcase
   end

   assign state_dbg = state_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench: three controllers (MEM_WAIT 0, 1, 3) checked cycle by
// cycle against a per-instruction expected output sequence.
module tb_mc_control_unit;
   import mc_ctrl_pkg::*;

   localparam int ND = 3;

   logic        clk    = 1'b0;
   logic        reset  = 1'b1;
   logic [5:0]  opcode = 6'd0;
   logic [5:0]  funct  = 6'd0;
   logic [19:0] obs [ND];
   logic [4:0]  st  [ND];
   logic [19:0] exp_q [$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      logic [1:0] ulaa, ulab, pcsrc;
      logic [2:0] ulaop;
      logic       iord, memw, irw, mdrw, aluw, regw, regdst, m2r, pcw, pcwc, operr;
      logic [4:0] sdbg;
      mc_control_unit #(.MEM_WAIT(g == 0 ? 0 : (g == 1 ? 1 : 3))) dut (
         .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
         .ULAa(ulaa), .ULAb(ulab), .ULAop(ulaop), .IorD(iord), .MemWrite(memw),
         .IRWrite(irw), .MDRWrite(mdrw), .ALUOutWrite(aluw), .RegWrite(regw),
         .RegDst(regdst), .MemtoReg(m2r), .PCWrite(pcw), .PCWriteCond(pcwc),
         .PCSource(pcsrc), .op_error(operr), .state_dbg(sdbg)
      );
      assign obs[g] = {ulaa, ulab, ulaop, iord, memw, irw, mdrw, aluw, regw,
                       regdst, m2r, pcw, pcwc, pcsrc, operr};
      assign st[g]  = sdbg;
   end

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
   endfunction

   // Field order: ULAa ULAb ULAop IorD MemWrite IRWrite MDRWrite ALUOutWrite
   // RegWrite RegDst MemtoReg PCWrite PCWriteCond PCSource op_error
   function automatic logic [19:0] vec(input logic [1:0] a, input logic [1:0] b,
      input logic [2:0] op, input logic iord, input logic memw, input logic irw,
      input logic mdrw, input logic aluw, input logic regw, input logic regdst,
      input logic m2r, input logic pcw, input logic pcwc, input logic [1:0] pcs,
      input logic err);
      return {a, b, op, iord, memw, irw, mdrw, aluw, regw, regdst, m2r, pcw, pcwc, pcs, err};
   endfunction

   // Expected per-cycle outputs for one instruction, starting at fetch.
   function automatic void build_exp(input int w, input logic [5:0] op, input logic [5:0] fn);
      logic [19:0] ill;
      logic [19:0] addr;
      logic [2:0]  rop;
      ill  = vec(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
      addr = vec(2'b10, 2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      exp_q.delete();
      for (int i = 0; i <= w; i++) exp_q.push_back(20'd0);
      exp_q.push_back(vec(2'b00, 2'b01, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
      exp_q.push_back(vec(2'b00, 2'b11, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      case (op)
         6'h00: begin
            rop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000;
            if (rop != 3'b000) begin
               exp_q.push_back(vec(2'b10, 2'b00, rop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
               exp_q.push_back(vec(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
            end else begin
               exp_q.push_back(vec(2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
               exp_q.push_back(ill);
            end
         end
         6'h08: begin
            exp_q.push_back(addr);
            exp_q.push_back(vec(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
         end
         6'h23: begin
            exp_q.push_back(addr);
            for (int i = 0; i <= w; i++)
               exp_q.push_back(vec(2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
            exp_q.push_back(vec(2'b00, 2'b00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
            exp_q.push_back(vec(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0));
         end
         6'h2B: begin
            exp_q.push_back(addr);
            exp_q.push_back(vec(2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
         end
         6'h04: exp_q.push_back(vec(2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0));
         6'h02: exp_q.push_back(vec(2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0));
         default: exp_q.push_back(ill);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
      build_exp(wait_of(k), op, fn);
      chk($sformatf("w%0d_op%02h_start", wait_of(k), op), 32'(st[k]), 32'(ST_FETCH));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("w%0d_op%02h_fn%02h_cyc%0d", wait_of(k), op, fn, i), 32'(obs[k]), 32'(exp_q[i]));
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset(input int k);
      reset = 1'b1;
      #1;
      chk("rst_async_state", 32'(st[k]), 32'd0);
      chk("rst_async_outs", 32'(obs[k]), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [5:0] rop, rfn;
      int         sel;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
         chk($sformatf("rst_hold_state%0d", k), 32'(st[k]), 32'd0);
         chk($sformatf("rst_hold_outs%0d", k), 32'(obs[k]), 32'd0);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      for (int n = 0; n < ND; n++) begin
         sel = (n + 1) % ND;
         if (n != 0) do_reset(sel);
         run_instr(sel, 6'h00, 6'h22);
         run_instr(sel, 6'h23, 6'h00);
         run_instr(sel, 6'h04, 6'h00);
         run_instr(sel, 6'h02, 6'h00);
         run_instr(sel, 6'h3F, 6'h00);
         run_instr(sel, 6'h00, 6'h2A);
         run_instr(sel, 6'h00, 6'h20);
         run_instr(sel, 6'h00, 6'h24);
         run_instr(sel, 6'h08, 6'h00);
         run_instr(sel, 6'h2B, 6'h00);
         for (int r = 0; r < 25; r++) begin
            rfn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
               0: begin rop = 6'h00; rfn = 6'h20 + 6'(2 * $urandom_range(0, 2)); end
               1: rop = 6'h00;
               2: rop = 6'h08;
               3: rop = 6'h23;
               4: rop = 6'h2B;
               5: rop = 6'h04;
               6: rop = 6'h02;
               default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(sel, rop, rfn);
         end
         // sw aborted by reset while MemWrite is high
         opcode = 6'h2B;
         build_exp(wait_of(sel), 6'h2B, 6'h00);
         chk("sw_abort_start", 32'(st[sel]), 32'(ST_FETCH));
         for (int i = 0; i < exp_q.size() - 1; i++) begin
            chk($sformatf("sw_abort_cyc%0d", i), 32'(obs[sel]), 32'(exp_q[i]));
            @(posedge clk); #1;
         end
         chk("sw_abort_memwrite_hi", 32'(obs[sel][11]), 32'd1);
         #2;
         reset = 1'b1;
         #1;
         chk("sw_abort_memwrite_lo", 32'(obs[sel][11]), 32'd0);
         chk("sw_abort_regwrite", 32'(obs[sel][7]), 32'd0);
         chk("sw_abort_state", 32'(st[sel]), 32'd0);
         @(posedge clk); #1;
         reset = 1'b0;
         @(posedge clk); #1;
         chk("sw_abort_refetch", 32'(st[sel]), 32'(ST_FETCH));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
